// File: rtl/load_store_unit.sv
// Data-memory stage: byte/half/word loads and stores against an internal word RAM
// with a fixed access latency, a stall window per access and a fault pulse for rejected requests.
module load_store_unit #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Fault
);

    localparam int AW       = $clog2(DEPTH_WORDS);
    localparam int CNT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam int CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wr_q;
    logic [2:0]       f3_q;
    logic [AW+1:0]    addr_q;
    logic [31:0]      wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic req, f3_ok, align_ok, range_ok, req_valid, accept, commit;
    logic          cur_wr;
    logic [2:0]    cur_f3;
    logic [AW+1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [AW-1:0] widx;
    logic [3:0]    be;
    logic [31:0]   wd, rword, load_val;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;

    always_comb begin
        req = MemRead | MemWrite;
        if (MemWrite) f3_ok = funct3 inside {3'b000, 3'b001, 3'b010};
        else          f3_ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        align_ok  = !((funct3[1:0] == 2'b01) && Addr[0]) &&
                    !((funct3[1:0] == 2'b10) && (Addr[1:0] != 2'b00));
        range_ok  = {2'b00, Addr[31:2]} < 32'(DEPTH_WORDS);
        req_valid = req && !(MemRead && MemWrite) && f3_ok && align_ok && range_ok;
        accept    = (state_q == IDLE) && req_valid;
        // Reset gates both outputs so Stall drops the instant rst rises, even with a live request.
        Stall     = !rst && (accept || (state_q == WAIT));
        Fault     = !rst && (state_q == IDLE) && req && !req_valid;
    end

    // The commit edge uses live inputs when LATENCY==1 (commit straight from IDLE), latched ones otherwise.
    always_comb begin
        if (state_q == IDLE) begin
            cur_wr    = MemWrite;
            cur_f3    = funct3;
            cur_addr  = Addr[AW+1:0];
            cur_wdata = WriteData;
        end else begin
            cur_wr    = wr_q;
            cur_f3    = f3_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
        widx = cur_addr[AW+1:2];
        if (LATENCY == 1) commit = !rst && accept;
        else              commit = !rst && (state_q == WAIT) && (cnt_q == '0);
    end

    always_comb begin
        be = 4'b1111;
        wd = cur_wdata;
        case (cur_f3[1:0])
            2'b00: begin
                be = 4'b0001 << cur_addr[1:0];
                wd = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be = cur_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{cur_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rword = mem[widx];
        rbyte = rword[{cur_addr[1:0], 3'b000} +: 8];
        rhalf = cur_addr[1] ? rword[31:16] : rword[15:0];
        case (cur_f3)
            3'b000:  load_val = {{24{rbyte[7]}}, rbyte};
            3'b001:  load_val = {{16{rhalf[15]}}, rhalf};
            3'b100:  load_val = {24'h0, rbyte};
            3'b101:  load_val = {16'h0, rhalf};
            default: load_val = rword;
        endcase
    end

    // NOTE: the RAM has no reset so it maps onto plain memory; its power-up contents are undefined.
    always_ff @(posedge clk) begin
        if (commit && cur_wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[widx][8*b +: 8] <= wd[8*b +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            f3_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ReadData <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    wr_q    <= MemWrite;
                    f3_q    <= funct3;
                    addr_q  <= Addr[AW+1:0];
                    wdata_q <= WriteData;
                    cnt_q   <= CNT_W'(CNT_INIT);
                    state_q <= (LATENCY == 1) ? DONE : WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) state_q <= DONE;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                end
                default: state_q <= IDLE;
            endcase
            if (commit && !cur_wr) ReadData <= load_val;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit, checked against a byte-addressed
// memory model; a second LATENCY=1 instance covers the single-cycle build.
module tb_load_store_unit;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, read_data;
    logic        stall, fault;

    logic        r1_read, r1_write;
    logic [2:0]  r1_f3;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic        r1_stall, r1_fault;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0]  model_mem [4*DEPTH];
    logic [31:0] model_rd;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    load_store_unit #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .MemRead(mem_read), .MemWrite(mem_write),
        .funct3(funct3), .Addr(addr), .WriteData(wdata),
        .ReadData(read_data), .Stall(stall), .Fault(fault)
    );

    load_store_unit #(.DEPTH_WORDS(64), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .MemRead(r1_read), .MemWrite(r1_write),
        .funct3(r1_f3), .Addr(r1_addr), .WriteData(r1_wdata),
        .ReadData(r1_rdata), .Stall(r1_stall), .Fault(r1_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_valid(input bit rd, input bit wr, input logic [2:0] f3,
                                       input logic [31:0] a);
        int size;
        if (!(rd || wr) || (rd && wr)) return 0;
        if (wr && f3 > 3'd2) return 0;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
        size = 1 << f3[1:0];
        if (a % size != 0) return 0;
        if ((a >> 2) >= DEPTH) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int size = 1 << f3[1:0];
        logic [31:0] v = 0;
        for (int i = 0; i < size; i++) v = v | (32'(model_mem[a + i]) << (8 * i));
        if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int size = 1 << f3[1:0];
        for (int i = 0; i < size; i++) model_mem[a + i] = 8'(d >> (8 * i));
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = d;
    endtask

    task automatic garbage();
        drive(1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom);
    endtask

    task automatic do_idle();
        drive(0, 0, 3'($urandom), $urandom, $urandom);
        @(negedge clk);
        check("idle_stall", 32'(stall), 0);
        check("idle_fault", 32'(fault), 0);
        check("idle_rdata", read_data, model_rd);
        @(posedge clk); #1;
    endtask

    // Called one step after a rising edge; returns one step after the edge that leaves DONE
    // (or the faulting IDLE cycle), so calls chain back-to-back.
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] obs);
        bit v = model_valid(rd, wr, f3, a);
        logic [31:0] exp = model_rd;
        int n_stall = 1;
        drive(rd, wr, f3, a, d);
        @(negedge clk);
        if (!v) begin
            check("fault_hi", 32'(fault), 1);
            check("fault_stall", 32'(stall), 0);
            check("fault_rdata", read_data, model_rd);
            obs = read_data;
            @(posedge clk); #1;
        end else begin
            if (wr) model_store(f3, a, d);
            else    exp = model_load(f3, a);
            model_rd = exp;
            check("acc_stall_first", 32'(stall), 1);
            check("acc_fault", 32'(fault), 0);
            @(posedge clk); #1;
            garbage();
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (!stall) break;
                n_stall++;
                check("wait_fault", 32'(fault), 0);
                @(posedge clk); #1;
            end
            check("stall_cycles", 32'(n_stall), 32'(LAT));
            check("done_fault", 32'(fault), 0);
            check("done_rdata", read_data, exp);
            obs = read_data;
            @(posedge clk); #1;
            drive(0, 0, 3'd0, 32'd0, 32'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] obs;
        int c0;
        bit rd, wr;
        logic [2:0] f3;
        logic [31:0] a;

        rst = 1'b1;
        drive(0, 0, 3'd0, 32'd0, 32'd0);
        r1_read = 0; r1_write = 0; r1_f3 = 0; r1_addr = 0; r1_wdata = 0;
        model_rd = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_rdata", read_data, 0);
        check("rst_rdata_l1", r1_rdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int w = 0; w < 16; w++) do_access(0, 1, 3'd2, 32'(4 * w), 32'd0, obs);

        do_access(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, obs);
        do_access(1, 0, 3'd2, 32'h10, 32'h0, obs);
        check("lw_deadbeef", obs, 32'hDEADBEEF);

        do_access(0, 1, 3'd2, 32'h10, 32'h0, obs);
        do_access(0, 1, 3'd0, 32'h13, 32'h80, obs);
        do_access(1, 0, 3'd2, 32'h10, 32'h0, obs);
        check("lw_after_sb", obs, 32'h80000000);
        do_access(1, 0, 3'd0, 32'h13, 32'h0, obs);
        check("lb_sext", obs, 32'hFFFFFF80);
        do_access(1, 0, 3'd4, 32'h13, 32'h0, obs);
        check("lbu_zext", obs, 32'h00000080);
        do_access(1, 0, 3'd5, 32'h12, 32'h0, obs);
        check("lhu_zext", obs, 32'h00008000);

        do_access(1, 0, 3'd2, 32'h12, 32'h0, obs);
        do_access(0, 1, 3'd1, 32'h11, 32'hFFFF, obs);
        do_access(1, 0, 3'd2, 32'h1000, 32'h0, obs);
        do_access(1, 1, 3'd2, 32'h10, 32'h5555AAAA, obs);
        do_access(1, 0, 3'd3, 32'h10, 32'h0, obs);
        do_idle();
        do_access(1, 0, 3'd2, 32'h10, 32'h0, obs);
        check("ram_after_faults", obs, 32'h80000000);

        do_access(0, 1, 3'd2, 32'h20, 32'hAAAAAAAA, obs);
        drive(0, 1, 3'd2, 32'h20, 32'h12345678);
        @(negedge clk);
        check("rst_mid_stall_on", 32'(stall), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_async_stall", 32'(stall), 0);
        @(negedge clk);
        check("rst_held_stall", 32'(stall), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_rd = 0;
        do_idle();
        do_access(1, 0, 3'd2, 32'h20, 32'h0, obs);
        check("store_aborted", obs, 32'hAAAAAAAA);

        c0 = cyc;
        do_access(0, 1, 3'd2, 32'h4, 32'h11, obs);
        do_access(1, 0, 3'd2, 32'h4, 32'h0, obs);
        check("b2b_value", obs, 32'h11);
        check("b2b_cycles", 32'(cyc - c0), 32'(2 * (LAT + 1)));

        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_idle();
            end else begin
                wr = ($urandom_range(0, 1) == 1);
                rd = !wr;
                if ($urandom_range(0, 15) == 0) begin rd = 1; wr = 1; end
                if (wr) f3 = 3'($urandom_range(0, 2));
                else begin
                    case ($urandom_range(0, 4))
                        0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                    endcase
                end
                if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
                a = 32'($urandom_range(0, 15) * 4);
                a = a + 32'(($urandom_range(0, 3) >> f3[1:0]) << f3[1:0]);
                if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
                if ($urandom_range(0, 15) == 0) a = $urandom | 32'h0000_1000;
                do_access(rd, wr, f3, a, $urandom, obs);
            end
        end

        r1_write = 1; r1_read = 0; r1_f3 = 3'd2; r1_addr = 32'h8; r1_wdata = 32'hCAFEF00D;
        @(negedge clk);
        check("l1_sw_stall", 32'(r1_stall), 1);
        @(posedge clk); #1;
        r1_read = 1; r1_write = 1; r1_addr = $urandom;
        @(negedge clk);
        check("l1_sw_done", 32'(r1_stall), 0);
        check("l1_done_fault", 32'(r1_fault), 0);
        @(posedge clk); #1;
        r1_read = 1; r1_write = 0; r1_f3 = 3'd2; r1_addr = 32'h8;
        @(negedge clk);
        check("l1_lw_stall", 32'(r1_stall), 1);
        @(posedge clk); #1;
        r1_addr = 32'h0;
        @(negedge clk);
        check("l1_lw_done", 32'(r1_stall), 0);
        check("l1_lw_data", r1_rdata, 32'hCAFEF00D);
        @(posedge clk); #1;
        r1_f3 = 3'd0; r1_addr = 32'hB;
        @(posedge clk); #1;
        r1_read = 0;
        @(negedge clk);
        check("l1_lb_data", r1_rdata, 32'hFFFFFFCA);
        @(posedge clk); #1;
        r1_read = 1; r1_f3 = 3'd2; r1_addr = 32'h100;
        @(negedge clk);
        check("l1_range_fault", 32'(r1_fault), 1);
        check("l1_range_stall", 32'(r1_stall), 0);
        @(posedge clk); #1;
        r1_read = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
